booth_mul_sched: RTL and testbench
==================================

// Module: booth_mul_sched
// PURPOSE
//  Shares one 12x12 Booth multiplier datapath (Booth encoder -> PP compressor -> C/S) between two requesters.
//  Arbitrates requests, drives operands, waits out datapath stages, captures the carry/sum vectors,
//  performs the final 24-bit carry-propagate add and returns the product with the requester ID.
//  Sits between the issuing units and the combinational (or pipelined) Booth/ppCompressor path.
// PARAMETERS
//  W          12  operand width; product width is 2*W (fixed 12 in this design, widths derive from W)
//  DP_STAGES  0   register stages inside the datapath between _dp_mcand/_dp_mplier and _dp_C/_dp_S (0..7)
// PORTS
//  _clk         in   1    clock, rising edge
//  _rst         in   1    reset, synchronous, active-high
//  _req0_valid  in   1    requester 0 has operands
//  _req0_ready  out  1    requester 0 accepted this cycle
//  _req0_a      in   W    requester 0 multiplicand, signed
//  _req0_b      in   W    requester 0 multiplier, signed
//  _req1_valid  in   1    requester 1 has operands
//  _req1_ready  out  1    requester 1 accepted this cycle
//  _req1_a      in   W    requester 1 multiplicand, signed
//  _req1_b      in   W    requester 1 multiplier, signed
//  _dp_mcand    out  W    operand to Booth PP generator
//  _dp_mplier   out  W    multiplier to Booth encoder
//  _dp_C        in   2W   carry vector from PP compressor (bit 0 always 0)
//  _dp_S        in   2W   sum vector from PP compressor
//  _rsp_valid   out  1    product available
//  _rsp_ready   in   1    consumer takes product
//  _rsp_id      out  1    requester that issued the product
//  _rsp_p       out  2W   signed product, two's complement
//  _busy        out  1    state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; _rsp_valid=0; _rsp_p=0; _rsp_id=0; _dp_mcand=_dp_mplier=0; wait cnt=0; rr pointer last=1.
//  FSM IDLE -> EVAL -> ADD -> RESP -> IDLE.
//  IDLE: _reqN_ready = grant_N (combinational from valids, only in IDLE; 0 in all other states).
//   Only one valid -> grant it. Both valid -> grant requester != last; last <= granted ID on accept.
//   Accept (valid&ready): latch a->_dp_mcand, b->_dp_mplier, ID, cnt<=0, -> EVAL. No valid: stay.
//  EVAL: _dp_* held stable. cnt increments each cycle; when cnt==DP_STAGES, capture C<=_dp_C, S<=_dp_S, -> ADD.
//   DP_STAGES=0 -> exactly one cycle in EVAL.
//  ADD: _rsp_p <= (C+S) mod 2^(2W) (carry-out discarded); _rsp_id <= ID; _rsp_valid <= 1; -> RESP.
//  RESP: _rsp_valid=1, _rsp_p/_rsp_id stable until _rsp_ready=1; on handshake _rsp_valid<=0, -> IDLE.
//  Latency: accept edge -> _rsp_valid high = DP_STAGES+3 rising edges (EVAL entry, EVAL capture, ADD).
//  Throughput: one product per DP_STAGES+4 cycles with _rsp_ready tied high; no request accepted outside IDLE.
//  _dp_* keep last operands in IDLE (no toggling of datapath between jobs).
//  Valid dropped without ready: no state change; requester must hold operands until ready (not checked).
//  _rst asserted in any state: next edge returns to reset values; in-flight job and pending product discarded.
//  Arithmetic: -2^(W-1)*-2^(W-1) = +2^(2W-2) fits 2W bits; no overflow case exists.
// CONFIGURATION
//  BOOTH_SCHED_FIXED_PRIO_EN defined: requester 0 always wins ties; rr pointer removed.
//  Not defined (default): round-robin tie-break as above.
// TESTING (golden model: _rsp_p == a*b signed 24-bit, datapath = real Booth encoder + ppCompressor)
//  Single req0 a=3,b=5, rsp_ready=1 -> _rsp_p=0x00000F, id=0, valid 3 cycles after accept (DP_STAGES=0).
//  req1 a=-2048,b=-2048 -> 0x400000; a=2047,b=-2048 -> 0xC00800; a=-1,b=1 -> 0xFFFFFF.
//  Both valid continuously, 8 jobs -> ids 0,1,0,1,...; with BOOTH_SCHED_FIXED_PRIO_EN all ids 0.
//  rsp_ready low 5 cycles in RESP -> rsp_p/rsp_id stable, both req ready=0, busy=1; then handshake -> IDLE.
//  _rst pulsed in EVAL and in RESP -> next cycle rsp_valid=0, busy=0, next tie grants req0.
//  DP_STAGES=2 with registered datapath model -> latency 5, 10k random operands match golden model.

Source files
------------

// File: rtl/booth_mul_sched.sv
// Scheduler that shares one Booth multiplier datapath between two requesters and adds its carry/sum vectors.
// Define BOOTH_SCHED_FIXED_PRIO_EN to make requester 0 win every tie; round-robin otherwise.
module booth_mul_sched #(
  parameter int W         = 12,
  parameter int DP_STAGES = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [W-1:0]     i_req0_a,
  input  logic [W-1:0]     i_req0_b,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [W-1:0]     i_req1_a,
  input  logic [W-1:0]     i_req1_b,
  output logic [W-1:0]     o_dp_mcand,
  output logic [W-1:0]     o_dp_mplier,
  input  logic [2*W-1:0]   i_dp_C,
  input  logic [2*W-1:0]   i_dp_S,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_id,
  output logic [2*W-1:0]   o_rsp_p,
  output logic             o_busy
);

  typedef enum logic [1:0] {IDLE, EVAL, ADD, RESP} state_t;

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic             r_id;
  logic [2*W-1:0]   r_c;
  logic [2*W-1:0]   r_s;
  logic [W-1:0]     r_mcand;
  logic [W-1:0]     r_mplier;
  logic [2*W-1:0]   r_rsp_p;
  logic             r_rsp_id;
  logic             r_rsp_valid;

  logic             w_idle;
  logic             w_grant0;
  logic             w_grant1;

  assign w_idle = (r_state == IDLE);

`ifdef BOOTH_SCHED_FIXED_PRIO_EN
  assign w_grant1 = w_idle & i_req1_valid & ~i_req0_valid;
`else
  logic r_last;
  // On a tie, serve whichever requester was not served last.
  assign w_grant1 = w_idle & i_req1_valid & (~i_req0_valid | ~r_last);
`endif
  assign w_grant0 = w_idle & i_req0_valid & ~w_grant1;

  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;
  assign o_dp_mcand   = r_mcand;
  assign o_dp_mplier  = r_mplier;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_p      = r_rsp_p;
  assign o_busy       = ~w_idle;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= 3'd0;
      r_id        <= 1'b0;
      r_c         <= '0;
      r_s         <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_rsp_p     <= '0;
      r_rsp_id    <= 1'b0;
      r_rsp_valid <= 1'b0;
`ifndef BOOTH_SCHED_FIXED_PRIO_EN
      r_last      <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant0 | w_grant1) begin
            r_mcand  <= w_grant1 ? i_req1_a : i_req0_a;
            r_mplier <= w_grant1 ? i_req1_b : i_req0_b;
            r_id     <= w_grant1;
            r_cnt    <= 3'd0;
            r_state  <= EVAL;
`ifndef BOOTH_SCHED_FIXED_PRIO_EN
            r_last   <= w_grant1;
`endif
          end
        end
        EVAL: begin
          // Operands stay put while the datapath pipeline fills.
          if (r_cnt == 3'(DP_STAGES)) begin
            r_c     <= i_dp_C;
            r_s     <= i_dp_S;
            r_state <= ADD;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        ADD: begin
          r_rsp_p     <= r_c + r_s;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_sched.sv
// Bench for booth_mul_sched: behavioural datapath + scoreboard model checked every cycle, plus directed literal cases.
// Honours BOOTH_SCHED_FIXED_PRIO_EN for the expected tie-break.
module tb_booth_mul_sched;
  localparam int W   = 12;
  localparam int DP  = 0;
  localparam int LAT = DP + 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_rst = 1'b1;
  logic        i_req0_valid = 1'b0, i_req1_valid = 1'b0;
  logic [11:0] i_req0_a = '0, i_req0_b = '0, i_req1_a = '0, i_req1_b = '0;
  logic        i_rsp_ready = 1'b0;
  logic        o_req0_ready, o_req1_ready, o_rsp_valid, o_rsp_id, o_busy;
  logic [11:0] o_dp_mcand, o_dp_mplier;
  logic [23:0] i_dp_C, i_dp_S, o_rsp_p;

  booth_mul_sched #(.W(W), .DP_STAGES(DP)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready), .i_req0_a(i_req0_a), .i_req0_b(i_req0_b),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready), .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
    .o_dp_mcand(o_dp_mcand), .o_dp_mplier(o_dp_mplier), .i_dp_C(i_dp_C), .i_dp_S(i_dp_S),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_id(o_rsp_id), .o_rsp_p(o_rsp_p),
    .o_busy(o_busy)
  );

  function automatic logic [23:0] prod24(input logic [11:0] a, input logic [11:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[23:0];
  endfunction

  // Datapath stand-in: any carry/sum split whose sum is the product, carry bit 0 clear.
  logic [23:0] dp_c0, dp_s0;
  always_comb begin
    dp_c0 = {o_dp_mcand, o_dp_mplier} & 24'hFFFFFE;
    dp_s0 = prod24(o_dp_mcand, o_dp_mplier) - dp_c0;
  end
  generate
    if (DP == 0) begin : g_comb
      assign i_dp_C = dp_c0;
      assign i_dp_S = dp_s0;
    end else begin : g_pipe
      logic [23:0] pc [1:DP];
      logic [23:0] ps [1:DP];
      always @(posedge clk) begin
        pc[1] <= dp_c0;
        ps[1] <= dp_s0;
        for (int i = 2; i <= DP; i++) begin
          pc[i] <= pc[i-1];
          ps[i] <= ps[i-1];
        end
      end
      assign i_dp_C = pc[DP];
      assign i_dp_S = ps[DP];
    end
  endgenerate

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard model: busy from accept to response handshake, response after LAT edges.
  typedef struct packed { logic id; logic [23:0] p; } job_t;
  job_t        exp_q[$];
  logic        got_ids[$];
  logic        m_known = 1'b0, m_busy = 1'b0, m_last = 1'b1;
  int          m_age = 0;
  logic [11:0] m_a = '0, m_b = '0;

  always @(negedge clk) begin : monitor
    logic e_r0, e_r1, e_v;
`ifdef BOOTH_SCHED_FIXED_PRIO_EN
    e_r1 = !m_busy && i_req1_valid && !i_req0_valid;
`else
    e_r1 = !m_busy && i_req1_valid && (!i_req0_valid || !m_last);
`endif
    e_r0 = !m_busy && i_req0_valid && !e_r1;
    e_v  = m_busy && (m_age >= LAT);
    if (m_known) begin
      chk("req0_ready", 32'(o_req0_ready), 32'(e_r0));
      chk("req1_ready", 32'(o_req1_ready), 32'(e_r1));
      chk("busy", 32'(o_busy), 32'(m_busy));
      chk("rsp_valid", 32'(o_rsp_valid), 32'(e_v));
      chk("dp_mcand", 32'(o_dp_mcand), 32'(m_a));
      chk("dp_mplier", 32'(o_dp_mplier), 32'(m_b));
      if (e_v && exp_q.size() > 0) begin
        chk("rsp_p", 32'(o_rsp_p), 32'(exp_q[0].p));
        chk("rsp_id", 32'(o_rsp_id), 32'(exp_q[0].id));
      end
    end
    if (i_rst) begin
      m_known = 1'b1; m_busy = 1'b0; m_last = 1'b1; m_age = 0;
      m_a = '0; m_b = '0;
      exp_q.delete();
    end else if (m_known) begin
      if (!m_busy) begin
        if (e_r0 || e_r1) begin
          m_a = e_r1 ? i_req1_a : i_req0_a;
          m_b = e_r1 ? i_req1_b : i_req0_b;
          m_last = e_r1;
          exp_q.push_back({e_r1, prod24(m_a, m_b)});
          m_busy = 1'b1;
          m_age  = 1;
        end
      end else if (e_v && i_rsp_ready) begin
        $display("[TB] rsp id=%0d p=0x%06h", o_rsp_id, o_rsp_p);
        got_ids.push_back(o_rsp_id);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_busy = 1'b0;
      end else begin
        m_age++;
      end
    end
  end

  // Values sampled at the falling edge before the next rising edge.
  logic        s_acc0, s_acc1, s_v, s_id, s_busy, s_r0, s_r1;
  logic [23:0] s_p;
  logic [11:0] s_mc;

  task automatic step();
    @(negedge clk);
    s_acc0 = i_req0_valid && o_req0_ready && !i_rst;
    s_acc1 = i_req1_valid && o_req1_ready && !i_rst;
    s_v = o_rsp_valid; s_id = o_rsp_id; s_p = o_rsp_p; s_busy = o_busy;
    s_r0 = o_req0_ready; s_r1 = o_req1_ready; s_mc = o_dp_mcand;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_rst = 1'b1;
    step();
    i_rst = 1'b0;
  endtask

  task automatic wait_accept(input logic id, input string name);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      step();
      acc = id ? s_acc1 : s_acc0;
    end
    chk({name, "_accepted"}, 32'(acc), 32'd1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    s_v = 1'b0;
    while (!s_v && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic do_job(input logic id, input logic [11:0] a, input logic [11:0] b,
                        input logic [23:0] exp_p, input string name);
    int lat;
    i_rsp_ready = 1'b1;
    if (id) begin i_req1_valid = 1'b1; i_req1_a = a; i_req1_b = b; end
    else    begin i_req0_valid = 1'b1; i_req0_a = a; i_req0_b = b; end
    wait_accept(id, name);
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    wait_rsp(lat);
    $display("[TB] job %s id=%0d a=0x%03h b=0x%03h p=0x%06h lat=%0d", name, id, a, b, s_p, lat);
    chk({name, "_lat"}, 32'(lat), 32'(LAT));
    chk({name, "_p"}, 32'(s_p), 32'(exp_p));
    chk({name, "_id"}, 32'(s_id), 32'(id));
  endtask

  task automatic drain();
    i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_rsp_ready = 1'b1;
    repeat (LAT + 4) step();
  endtask

  function automatic logic [11:0] rnd_op();
    logic [11:0] r;
    case ($urandom_range(0, 7))
      0: r = 12'h800;
      1: r = 12'h7FF;
      2: r = 12'hFFF;
      3: r = 12'h000;
      4: r = 12'h001;
      default: r = 12'($urandom);
    endcase
    return r;
  endfunction

  initial begin
    int lat;
    logic exp_id;
    // Reset state
    step(); step();
    i_rst = 1'b0;
    step();
    $display("[TB] reset: valid=%0d p=0x%06h id=%0d busy=%0d", s_v, s_p, s_id, s_busy);
    chk("rst_rsp_valid", 32'(s_v), 32'd0);
    chk("rst_rsp_p", 32'(s_p), 32'd0);
    chk("rst_rsp_id", 32'(s_id), 32'd0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_dp_mcand", 32'(s_mc), 32'd0);

    // Single-requester products, including the extremes
    do_job(1'b0, 12'd3,   12'd5,   24'h00000F, "r0_3x5");
    do_job(1'b1, 12'h800, 12'h800, 24'h400000, "r1_min_x_min");
    do_job(1'b1, 12'h7FF, 12'h800, 24'hC00800, "r1_max_x_min");
    do_job(1'b1, 12'hFFF, 12'h001, 24'hFFFFFF, "r1_m1_x_1");

    // Both valid continuously: tie-break sequence
    do_reset();
    got_ids.delete();
    i_rsp_ready = 1'b1;
    i_req0_valid = 1'b1; i_req0_a = 12'd7;  i_req0_b = 12'd9;
    i_req1_valid = 1'b1; i_req1_a = 12'hFF0; i_req1_b = 12'd33;
    for (int n = 0; n < 200 && got_ids.size() < 8; n++) begin
      step();
      if (s_acc0) i_req0_a = i_req0_a + 12'd1;
      if (s_acc1) i_req1_b = i_req1_b - 12'd5;
    end
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    chk("tie_jobs", 32'(got_ids.size()), 32'd8);
    for (int k = 0; k < 8 && k < got_ids.size(); k++) begin
`ifdef BOOTH_SCHED_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = 1'(k % 2);
`endif
      chk($sformatf("tie_id%0d", k), 32'(got_ids[k]), 32'(exp_id));
    end
    drain();

    // Consumer stalls five cycles in RESP
    i_rsp_ready = 1'b0;
    i_req0_valid = 1'b1; i_req0_a = 12'd100; i_req0_b = 12'hFFD;
    wait_accept(1'b0, "stall");
    i_req0_a = 12'd1; i_req1_valid = 1'b1; i_req1_a = 12'd2; i_req1_b = 12'd3;
    wait_rsp(lat);
    for (int k = 0; k < 5; k++) begin
      step();
      $display("[TB] stall cyc%0d valid=%0d p=0x%06h id=%0d busy=%0d rdy=%0d%0d", k, s_v, s_p, s_id, s_busy, s_r0, s_r1);
      chk("stall_valid", 32'(s_v), 32'd1);
      chk("stall_p", 32'(s_p), 32'hFFFED4);
      chk("stall_id", 32'(s_id), 32'd0);
      chk("stall_busy", 32'(s_busy), 32'd1);
      chk("stall_ready0", 32'(s_r0), 32'd0);
      chk("stall_ready1", 32'(s_r1), 32'd0);
    end
    i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_rsp_ready = 1'b1;
    step();
    step();
    chk("stall_release_busy", 32'(s_busy), 32'd0);
    chk("stall_release_valid", 32'(s_v), 32'd0);

    // Reset while in EVAL, then a tie must go to requester 0
    i_req1_valid = 1'b1; i_req1_a = 12'd5; i_req1_b = 12'd5;
    wait_accept(1'b1, "rst_eval");
    i_req1_valid = 1'b0; i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    step();
    $display("[TB] after EVAL reset: valid=%0d busy=%0d rdy=%0d%0d", s_v, s_busy, s_r0, s_r1);
    chk("rst_eval_valid", 32'(s_v), 32'd0);
    chk("rst_eval_busy", 32'(s_busy), 32'd0);
    chk("rst_eval_tie_r0", 32'(s_r0), 32'd1);
    chk("rst_eval_tie_r1", 32'(s_r1), 32'd0);
    drain();

    // Reset while holding a product in RESP
    i_rsp_ready = 1'b0;
    i_req1_valid = 1'b1; i_req1_a = 12'd11; i_req1_b = 12'd13;
    wait_accept(1'b1, "rst_resp");
    i_req1_valid = 1'b0;
    wait_rsp(lat);
    chk("rst_resp_reached", 32'(s_v), 32'd1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    step();
    $display("[TB] after RESP reset: valid=%0d busy=%0d rdy=%0d%0d", s_v, s_busy, s_r0, s_r1);
    chk("rst_resp_valid", 32'(s_v), 32'd0);
    chk("rst_resp_busy", 32'(s_busy), 32'd0);
    chk("rst_resp_tie_r0", 32'(s_r0), 32'd1);
    chk("rst_resp_tie_r1", 32'(s_r1), 32'd0);
    drain();

    // Random traffic with random back-pressure; checked by the scoreboard
    got_ids.delete();
    for (int n = 0; n < 2000; n++) begin
      i_rsp_ready = ($urandom_range(0, 9) < 7);
      if (!i_req0_valid && $urandom_range(0, 1) == 1) begin
        i_req0_valid = 1'b1; i_req0_a = rnd_op(); i_req0_b = rnd_op();
      end
      if (!i_req1_valid && $urandom_range(0, 1) == 1) begin
        i_req1_valid = 1'b1; i_req1_a = rnd_op(); i_req1_b = rnd_op();
      end
      step();
      if (s_acc0) i_req0_valid = 1'b0;
      if (s_acc1) i_req1_valid = 1'b0;
    end
    drain();
    chk("rand_progress", 32'(got_ids.size() > 150), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
